// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type encoding, head-flit field offsets and packetizer states.
// The router decodes flits with the same package.
package noc_pkg;

  localparam int FLIT_TYPE_W   = 2;
  localparam int HEAD_DEST_LSB = 0;

  typedef enum logic [1:0] {
    FLIT_BODY = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_TAIL = 2'b10,
    FLIT_RSVD = 2'b11
  } flit_type_e;

  // PKTZ_HEAD is kept for the credit-based variant; today it behaves as PKTZ_IDLE.
  typedef enum logic [1:0] {
    PKTZ_IDLE    = 2'b00,
    PKTZ_HEAD    = 2'b01,
    PKTZ_PAYLOAD = 2'b10
  } pktz_state_e;

  function automatic int head_src_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int head_len_lsb(input int addr_w);
    return 2 * addr_w;
  endfunction

endpackage

// File: rtl/noc_flit_outreg.sv
// Valid/ready output pipeline register: loads when empty or draining, holds while stalled.
module noc_flit_outreg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             can_load_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign can_load_o = !valid_q || ready_i;
  assign valid_o    = valid_q;
  assign data_o     = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (can_load_o) begin
      valid_q <= load_i;
      if (load_i) data_q <= data_i;
    end
  end

endmodule

// File: rtl/noc_packetizer.sv
// Local-port network interface: turns one descriptor plus payload words into a
// wormhole packet (HEAD, BODY..., TAIL) on a registered valid/ready link.
module noc_packetizer
  import noc_pkg::*;
#(
  parameter int                    FLIT_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    LEN_WIDTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] SRC_ID     = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  msg_valid,
  output logic                  msg_ready,
  input  logic [ADDR_WIDTH-1:0] msg_dest,
  input  logic [LEN_WIDTH-1:0]  msg_len,
  input  logic                  pld_valid,
  output logic                  pld_ready,
  input  logic [FLIT_WIDTH-3:0] pld_data,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  len_err,
  output logic [15:0]           pkt_count
);

  localparam int SRC_LSB = head_src_lsb(ADDR_WIDTH);
  localparam int LEN_LSB = head_len_lsb(ADDR_WIDTH);

  pktz_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  len_err_q, len_err_d;
  logic [15:0]           pkt_count_q, pkt_count_d;
  logic                  can_load;
  logic                  load;
  logic [FLIT_WIDTH-1:0] flit_d;
  logic                  tail_xfer;

  noc_flit_outreg #(.WIDTH(FLIT_WIDTH)) u_outreg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .data_i     (flit_d),
    .ready_i    (ready_in),
    .can_load_o (can_load),
    .valid_o    (valid_out),
    .data_o     (flit_out)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    len_err_d = 1'b0;
    load      = 1'b0;
    flit_d    = '0;
    msg_ready = 1'b0;
    pld_ready = 1'b0;
    case (state_q)
      PKTZ_PAYLOAD: begin
        pld_ready = can_load;
        if (pld_valid && can_load) begin
          load   = 1'b1;
          rem_d  = rem_q - LEN_WIDTH'(1);
          flit_d = {(rem_q == LEN_WIDTH'(1)) ? FLIT_TAIL : FLIT_BODY, pld_data};
          if (rem_q == LEN_WIDTH'(1)) state_d = PKTZ_IDLE;
        end
      end
      default: begin
        // Head is loaded straight from idle; the reserved encodings fall back here too.
        state_d   = PKTZ_IDLE;
        msg_ready = can_load && !rst;
        if (msg_valid && msg_ready) begin
          if (msg_len == '0) begin
            len_err_d = 1'b1;
          end else begin
            load    = 1'b1;
            rem_d   = msg_len;
            state_d = PKTZ_PAYLOAD;
            flit_d[FLIT_WIDTH-1 -: FLIT_TYPE_W]         = FLIT_HEAD;
            flit_d[HEAD_DEST_LSB +: ADDR_WIDTH]         = msg_dest;
            flit_d[SRC_LSB +: ADDR_WIDTH]               = SRC_ID;
            flit_d[LEN_LSB +: LEN_WIDTH]                = msg_len;
          end
        end
      end
    endcase
  end

  assign tail_xfer   = valid_out && ready_in &&
                       (flit_out[FLIT_WIDTH-1 -: FLIT_TYPE_W] == FLIT_TAIL);
  assign pkt_count_d = tail_xfer ? pkt_count_q + 16'd1 : pkt_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PKTZ_IDLE;
      rem_q       <= '0;
      len_err_q   <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      len_err_q   <= len_err_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign len_err   = len_err_q;
  assign pkt_count = pkt_count_q;

endmodule
